// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: default widths,
// the storage state encoding and a state-to-occupancy helper.
package pipe_skid_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int IMM_W_DEF  = 16;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  function automatic logic [1:0] occupancy_of(input skid_state_e s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/imm_extend.sv
// Extends the low IMM_W bits of an instruction word to DATA_W bits,
// sign- or zero-filling the upper bits as selected by ext_sign.
module imm_extend
  import pipe_skid_stage_pkg::*;
#(
  parameter int IMM_W  = IMM_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] data,
  input  logic              ext_sign,
  output logic [DATA_W-1:0] imm
);

  // All-ones over the immediate field; zero-width upper part when IMM_W == DATA_W.
  localparam logic [DATA_W-1:0] LOW_MASK = {DATA_W{1'b1}} >> (DATA_W - IMM_W);

  logic fill;

  assign fill = ext_sign & data[IMM_W-1];
  assign imm  = (data & LOW_MASK) | ({DATA_W{fill}} & ~LOW_MASK);

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered instruction pipeline stage with flush, downstream
// hold, immediate extraction and a saturating stall-cycle counter.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMM_W  = IMM_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  input  logic              hold,
  input  logic              ext_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_imm,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  hold_cycles
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  hold_q;
  logic              push, pop, hold_inc;

  // in_ready depends on registered state only, so out_ready never reaches it.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY) && !hold;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign hold_inc  = hold && (state_q != ST_EMPTY) && (hold_q != {CNT_W{1'b1}});

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && !pop) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (push && pop) begin
            main_d  = in_data;
          end else if (pop) begin
            main_d  = '0;
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the data registers are reset (not just the state) because out_data
  // must present a zero NOP bubble whenever the stage is empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Stall counter survives flush; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
    end else if (hold_inc) begin
      hold_q <= hold_q + CNT_W'(1);
    end
  end

  assign out_data    = main_q;
  assign occupancy   = occupancy_of(state_q);
  assign hold_cycles = hold_q;

  imm_extend #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W)
  ) u_imm_extend (
    .data     (main_q),
    .ext_sign (ext_sign),
    .imm      (out_imm)
  );

endmodule
